// File: rtl/riscv_core_mul_pkg.sv
// Shared definitions for the radix-16 Booth multiplier: op encodings, digit type,
// the digit recoder and helpers that size the carry-save reduction tree.
package riscv_core_mul_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_MULW   = 3'b100;

  typedef logic signed [4:0] booth_digit_t;

  // window = {b[4i+3], b[4i+2], b[4i+1], b[4i], b[4i-1]}; value = -8w4 + 4w3 + 2w2 + w1 + w0
  function automatic booth_digit_t booth_recode(input logic [4:0] win);
    return $signed({win[4], win[4], win[3], win[2], win[1]}) + $signed({4'b0000, win[0]});
  endfunction

  function automatic int csa_rows(input int n0, input int lvl);
    int n = n0;
    for (int i = 0; i < lvl; i++) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction

  function automatic int csa_levels(input int n0);
    int n = n0;
    int l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + n % 3;
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/riscv_core_mul_booth16_pp.sv
// One radix-16 Booth digit: recode a 5-bit window of B, pick |digit|*A and
// one's-complement it for negative digits (the +1 is injected by the caller).
module riscv_core_mul_booth16_pp
  import riscv_core_mul_pkg::*;
#(
  parameter int PPW = 70
) (
  input  logic [4:0]     window,
  input  logic [PPW-1:0] m1,
  input  logic [PPW-1:0] m2,
  input  logic [PPW-1:0] m3,
  input  logic [PPW-1:0] m4,
  input  logic [PPW-1:0] m5,
  input  logic [PPW-1:0] m6,
  input  logic [PPW-1:0] m7,
  input  logic [PPW-1:0] m8,
  output logic [PPW-1:0] pp,
  output logic           neg
);

  booth_digit_t digit;
  logic [PPW-1:0] mag;

  assign digit = booth_recode(window);
  assign neg   = digit[4];

  always_comb begin
    mag = '0;
    case (digit)
      5'sd1, -5'sd1: mag = m1;
      5'sd2, -5'sd2: mag = m2;
      5'sd3, -5'sd3: mag = m3;
      5'sd4, -5'sd4: mag = m4;
      5'sd5, -5'sd5: mag = m5;
      5'sd6, -5'sd6: mag = m6;
      5'sd7, -5'sd7: mag = m7;
      5'sd8, -5'sd8: mag = m8;
      default:       mag = '0;
    endcase
  end

  assign pp = neg ? ~mag : mag;

endmodule

// File: rtl/riscv_core_mul_booth16.sv
// RV64M multiplier (MUL/MULH/MULHSU/MULHU/MULW): radix-16 Booth partial products,
// carry-save tree, one final adder, result register.
module riscv_core_mul_booth16
  import riscv_core_mul_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_mul_srcA,
  input  logic [XLEN-1:0] i_mul_srcB,
  input  logic [1:0]      i_mul_control,
  input  logic            i_mul_isword,
  input  logic            i_mul_en,
  output logic [XLEN-1:0] o_mul_result
);

  localparam int HALF  = XLEN / 2;
  localparam int EXTW  = XLEN + 2;
  localparam int PPW   = XLEN + 6;
  localparam int NDIG  = (XLEN + 4) / 4;
  localparam int ROWW  = 2 * XLEN;
  localparam int NROWS = NDIG + 2;
  localparam int NLVL  = csa_levels(NROWS);

  // Each PP is stored with its sign bit inverted; this constant restores the sign weights.
  function automatic logic [ROWW-1:0] sext_const();
    logic [ROWW-1:0] k = '0;
    for (int i = 0; i < NDIG; i++)
      if (PPW - 1 + 4 * i < ROWW) k = k - (ROWW'(1) << (PPW - 1 + 4 * i));
    return k;
  endfunction

  localparam logic [ROWW-1:0] SEXT_K = sext_const();

  logic [2:0]        op;
  logic              is_mulw, signed_a, signed_b;
  logic [XLEN-1:0]   a_src, b_src;
  logic [EXTW-1:0]   a_ext, b_ext;
  logic [4*NDIG:0]   b_pad;
  logic [PPW-1:0]    m1, m2, m3, m4, m5, m6, m7, m8;
  logic [PPW-1:0]    pp_raw [NDIG];
  logic [NDIG-1:0]   pp_neg;
  logic [ROWW-1:0]   pp_rows [NROWS];
  logic [ROWW-1:0]   inj;
  logic [ROWW-1:0]   prod;
  logic [XLEN-1:0]   result;

  assign op       = {i_mul_isword, i_mul_control};
  assign is_mulw  = (op == OP_MULW);
  assign signed_a = (op != OP_MULHU);
  assign signed_b = (op != OP_MULHU) && (op != OP_MULHSU);

  assign a_src = is_mulw ? {{HALF{i_mul_srcA[HALF-1]}}, i_mul_srcA[HALF-1:0]} : i_mul_srcA;
  assign b_src = is_mulw ? {{HALF{i_mul_srcB[HALF-1]}}, i_mul_srcB[HALF-1:0]} : i_mul_srcB;
  assign a_ext = {{2{signed_a & a_src[XLEN-1]}}, a_src};
  assign b_ext = {{2{signed_b & b_src[XLEN-1]}}, b_src};
  assign b_pad = {{2{b_ext[EXTW-1]}}, b_ext, 1'b0};

  assign m1 = {{(PPW-EXTW){a_ext[EXTW-1]}}, a_ext};
  assign m2 = m1 << 1;
  assign m3 = m1 + m2;
  assign m4 = m1 << 2;
  assign m5 = m4 + m1;
  assign m6 = m3 << 1;
  assign m7 = m4 + m3;
  assign m8 = m1 << 3;

  for (genvar d = 0; d < NDIG; d++) begin : g_pp
    riscv_core_mul_booth16_pp #(.PPW(PPW)) u_pp (
      .window (b_pad[4*d +: 5]),
      .m1     (m1),
      .m2     (m2),
      .m3     (m3),
      .m4     (m4),
      .m5     (m5),
      .m6     (m6),
      .m7     (m7),
      .m8     (m8),
      .pp     (pp_raw[d]),
      .neg    (pp_neg[d])
    );
    assign pp_rows[d] = ROWW'({~pp_raw[d][PPW-1], pp_raw[d][PPW-2:0]}) << (4 * d);
  end

  always_comb begin
    inj = '0;
    for (int d = 0; d < NDIG; d++) inj = inj | (ROWW'(pp_neg[d]) << (4 * d));
  end

  assign pp_rows[NDIG]   = inj;
  assign pp_rows[NDIG+1] = SEXT_K;

  // 3:2 compression per level; leftover rows pass straight through
  for (genvar l = 0; l < NLVL; l++) begin : g_lvl
    localparam int N  = csa_rows(NROWS, l);
    localparam int NN = csa_rows(NROWS, l + 1);
    localparam int G  = N / 3;
    localparam int R  = N % 3;
    logic [ROWW-1:0] src [N];
    logic [ROWW-1:0] nxt [NN];
    if (l == 0) begin : g_first
      assign src = pp_rows;
    end else begin : g_next
      assign src = g_lvl[l-1].nxt;
    end
    for (genvar g = 0; g < G; g++) begin : g_csa
      assign nxt[2*g]   = src[3*g] ^ src[3*g+1] ^ src[3*g+2];
      assign nxt[2*g+1] = ((src[3*g] & src[3*g+1]) | (src[3*g] & src[3*g+2]) |
                           (src[3*g+1] & src[3*g+2])) << 1;
    end
    for (genvar r = 0; r < R; r++) begin : g_pass
      assign nxt[2*G+r] = src[3*G+r];
    end
  end

  assign prod = g_lvl[NLVL-1].nxt[0] + g_lvl[NLVL-1].nxt[1];

  always_comb begin
    result = prod[XLEN-1:0];
    case (op)
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod[ROWW-1:XLEN];
      OP_MULW:                      result = {{HALF{prod[HALF-1]}}, prod[HALF-1:0]};
      default:                      result = prod[XLEN-1:0];
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         o_mul_result <= '0;
    else if (i_mul_en) o_mul_result <= result;
  end

endmodule

// File: tb/tb_riscv_core_mul_booth16.sv
// Bench for riscv_core_mul_booth16: directed corner cases, enable/reset control,
// and random vectors against a 128-bit arithmetic reference model.
module tb_riscv_core_mul_booth16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] a = '0, b = '0;
  logic [1:0]  ctrl = '0;
  logic        isw = 1'b0;
  logic        en = 1'b0;
  logic [63:0] res;
  logic [63:0] exp_q;
  int          total = 0;
  int          bad = 0;

  riscv_core_mul_booth16 #(.XLEN(64)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_mul_srcA    (a),
    .i_mul_srcB    (b),
    .i_mul_control (ctrl),
    .i_mul_isword  (isw),
    .i_mul_en      (en),
    .o_mul_result  (res)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                          input logic [1:0] c, input logic w);
    logic [127:0] xe, ye, p;
    if (w && c == 2'b00) begin
      xe = {{96{x[31]}}, x[31:0]};
      ye = {{96{y[31]}}, y[31:0]};
      p  = xe * ye;
      return {{32{p[31]}}, p[31:0]};
    end
    if (w) c = 2'b00;
    xe = (c == 2'b11) ? {64'b0, x} : {{64{x[63]}}, x};
    ye = (c[1])       ? {64'b0, y} : {{64{y[63]}}, y};
    p  = xe * ye;
    return (c == 2'b00) ? p[63:0] : p[127:64];
  endfunction

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 64'h0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h1;
      4:       return {32'h0, $urandom()};
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] expv);
    total++;
    assert (res === expv) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, res, expv);
    end
  endtask

  task automatic op(input string tag, input logic [63:0] x, input logic [63:0] y,
                    input logic [1:0] c, input logic w, input logic [63:0] expv);
    @(negedge clk);
    a = x; b = y; ctrl = c; isw = w; en = 1'b1;
    @(posedge clk);
    #1;
    check(tag, expv);
    exp_q = expv;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 check("reset_value", 64'h0);
    en = 1'b1; a = 64'd3; b = '1;
    @(posedge clk);
    #1 check("reset_hold", 64'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_q = '0;

    op("mul_3x_m1",    64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD);
    op("mulh_min",     64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b01, 1'b0,
       64'h4000_0000_0000_0000);
    op("mulh_ones",    '1, '1, 2'b01, 1'b0, 64'h0);
    op("mulhu_ones",   '1, '1, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
    op("mulhsu_ones",  '1, '1, 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    op("mulhsu_1",     64'd1, '1, 2'b10, 1'b0, 64'h0);
    op("mulw",         64'h0000_0001_7FFF_FFFF, 64'd2, 2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    op("mul_min",      64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b00, 1'b0, 64'h0);
    op("mulhu_min",    64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b11, 1'b0,
       64'h4000_0000_0000_0000);
    op("mulhsu_min",   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b10, 1'b0,
       64'hC000_0000_0000_0000);
    op("word_as_mul",  64'h0000_0001_0000_0003, 64'd2, 2'b01, 1'b1, 64'h0000_0002_0000_0006);

    @(negedge clk);
    a = 64'h1234_5678; b = 64'h9; ctrl = 2'b00; isw = 1'b0; en = 1'b0;
    @(posedge clk);
    #1 check("en_hold", exp_q);

    op("pre_reset", 64'd7, 64'd6, 2'b00, 1'b0, 64'd42);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("async_reset", 64'h0);
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    @(posedge clk);
    #1 check("post_reset", 64'h0);
    exp_q = '0;

    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      a    = rnd_operand();
      b    = rnd_operand();
      ctrl = 2'($urandom_range(0, 3));
      isw  = 1'($urandom_range(0, 1));
      en   = ($urandom_range(0, 7) != 0);
      if (en) exp_q = ref_mul(a, b, ctrl, isw);
      @(posedge clk);
      #1 check("random", exp_q);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
